// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns debounced button levels into press events,
// arbitrates them round-robin and queues button codes in a small FIFO.
module button_event_arbiter #(
    parameter int N      = 9,
    parameter int DEPTH  = 4,
    parameter int CODE_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [N-1:0]      debounced_i,
    input  logic              evt_ready_i,
    input  logic              clr_ovf_i,
    output logic              evt_valid_o,
    output logic [CODE_W-1:0] evt_code_o,
    output logic              overflow_o,
    output logic              busy_o
);
    localparam int PW = $clog2(N);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      prev_q, pending_q, pending_d, rise, gnt;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d, gnt_any, push, pop;
    logic [CODE_W-1:0] mem [DEPTH];
    int                idx;

    // Round-robin search starting at rr_ptr; a full FIFO blocks granting even if it pops this cycle.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (pending_q != '0 && count_q < (AW+1)'(DEPTH)) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!gnt_any && pending_q[idx]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = PW'(idx);
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = RUN;
        rise       = (state_q == RUN) ? (debounced_i & ~prev_q) : '0;
        pending_d  = (pending_q & ~gnt) | rise;
        overflow_d = (|(rise & pending_q & ~gnt)) | (overflow_q & ~clr_ovf_i);
        rr_ptr_d   = !gnt_any ? rr_ptr_q : (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
        push       = gnt_any;
        pop        = evt_valid_o & evt_ready_i;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    assign evt_valid_o = (count_q != '0);
    assign evt_code_o  = evt_valid_o ? mem[rd_ptr_q] : '0;
    assign overflow_o  = overflow_q;
    assign busy_o      = (|pending_q) | evt_valid_o;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= INIT;
            prev_q     <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= debounced_i;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= CODE_W'(gnt_idx);
    end
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed and randomized checks against a queue-based
// reference model of press detection, round-robin arbitration and event queueing.
module tb_button_event_arbiter;
    localparam int N      = 9;
    localparam int DEPTH  = 4;
    localparam int CODE_W = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      debounced = '0;
    logic              evt_ready = 1'b0;
    logic              clr_ovf = 1'b0;
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              overflow;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] m_prev, m_pend;
    int           m_rr;
    int           m_q[$];
    bit           m_ovf, m_init;

    button_event_arbiter #(.N(N), .DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk_i(clk), .reset_ni(reset_n), .debounced_i(debounced),
        .evt_ready_i(evt_ready), .clr_ovf_i(clr_ovf),
        .evt_valid_o(evt_valid), .evt_code_o(evt_code),
        .overflow_o(overflow), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference: a button index enters the queue when it wins the rotating search.
    task automatic model_step(input logic [N-1:0] d, input logic r, input logic c);
        logic [N-1:0] rs;
        int g;
        bit drop;
        rs   = m_init ? '0 : (d & ~m_prev);
        g    = -1;
        drop = 0;
        if (m_pend != '0 && m_q.size() < DEPTH)
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        for (int i = 0; i < N; i++)
            if (rs[i] && m_pend[i] && i != g) drop = 1;
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % N;
        end
        m_pend = m_pend | rs;
        m_ovf  = drop || (m_ovf && !c);
        m_prev = d;
        m_init = 0;
    endtask

    // Entered and left on a falling edge.
    task automatic cycle(input logic [N-1:0] d, input logic r, input logic c);
        chk("valid", evt_valid, int'(m_q.size() != 0));
        if (m_q.size() != 0) chk("code", evt_code, m_q[0]);
        chk("overflow", overflow, int'(m_ovf));
        chk("busy", busy, int'(m_pend != '0 || m_q.size() != 0));
        debounced = d;
        evt_ready = r;
        clr_ovf   = c;
        model_step(d, r, c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] d);
        debounced = d;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_code", evt_code, 0);
        m_q.delete();
        m_pend = '0;
        m_prev = '0;
        m_rr   = 0;
        m_ovf  = 0;
        m_init = 1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [N-1:0] d;
        int n6, rp;
        @(negedge clk);

        // Button held through reset produces nothing until released and pressed again.
        do_reset(9'h001);
        repeat (20) cycle(9'h001, 1'b1, 1'b0);
        chk("held_no_evt", evt_valid, 0);
        cycle(9'h000, 1'b1, 1'b0);
        cycle(9'h001, 1'b1, 1'b0);
        cycle(9'h001, 1'b1, 1'b0);
        chk("held_valid", evt_valid, 1);
        chk("held_code", evt_code, 0);
        idle(4);

        // Two-cycle latency of a lone press.
        cycle(9'h020, 1'b1, 1'b0);
        chk("lat_not_yet", evt_valid, 0);
        cycle(9'h020, 1'b1, 1'b0);
        chk("lat_valid", evt_valid, 1);
        chk("lat_code", evt_code, 5);
        cycle(9'h020, 1'b1, 1'b0);
        chk("lat_gone", evt_valid, 0);
        chk("lat_busy", busy, 0);
        idle(3);

        // Round-robin order.
        do_reset('0);
        cycle('0, 1'b1, 1'b0);
        cycle(9'h10A, 1'b1, 1'b0);
        cycle(9'h10A, 1'b1, 1'b0);
        chk("rr_a0", evt_code, 1);
        cycle(9'h10A, 1'b1, 1'b0);
        chk("rr_a1", evt_code, 3);
        cycle(9'h10A, 1'b1, 1'b0);
        chk("rr_a2", evt_code, 8);
        idle(3);
        cycle(9'h00A, 1'b1, 1'b0);
        cycle(9'h00A, 1'b1, 1'b0);
        chk("rr_b0", evt_code, 1);
        cycle(9'h00A, 1'b1, 1'b0);
        chk("rr_b1", evt_code, 3);
        idle(3);
        cycle(9'h002, 1'b1, 1'b0);
        cycle(9'h002, 1'b1, 1'b0);
        idle(3);
        cycle(9'h00A, 1'b1, 1'b0);
        cycle(9'h00A, 1'b1, 1'b0);
        chk("rr_c0", evt_code, 3);
        cycle(9'h00A, 1'b1, 1'b0);
        chk("rr_c1", evt_code, 1);
        idle(3);

        // Back-pressure: four queued, fifth waits in pending.
        do_reset('0);
        cycle('0, 1'b0, 1'b0);
        cycle(9'h001, 1'b0, 1'b0);
        cycle(9'h003, 1'b0, 1'b0);
        cycle(9'h007, 1'b0, 1'b0);
        cycle(9'h00F, 1'b0, 1'b0);
        repeat (3) cycle(9'h01F, 1'b0, 1'b0);
        chk("bp_busy", busy, 1);
        chk("bp_valid", evt_valid, 1);
        chk("bp_head", evt_code, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_order", evt_code, i);
            cycle(9'h01F, 1'b1, 1'b0);
        end
        chk("bp_no_ovf", overflow, 0);
        idle(3);

        // Overflow on a re-press while still pending behind a full FIFO.
        do_reset('0);
        cycle('0, 1'b0, 1'b0);
        cycle(9'h001, 1'b0, 1'b0);
        cycle(9'h003, 1'b0, 1'b0);
        cycle(9'h007, 1'b0, 1'b0);
        cycle(9'h00F, 1'b0, 1'b0);
        cycle(9'h04F, 1'b0, 1'b0);
        cycle(9'h00F, 1'b0, 1'b0);
        cycle(9'h04F, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1);
        cycle(9'h04F, 1'b0, 1'b1);
        chk("ovf_clr", overflow, 0);
        n6 = 0;
        repeat (12) begin
            if (evt_valid && evt_code == 6) n6++;
            cycle(9'h04F, 1'b1, 1'b0);
        end
        chk("ovf_once", n6, 1);
        idle(3);

        // Reset with events queued discards them.
        do_reset('0);
        cycle('0, 1'b0, 1'b0);
        cycle(9'h001, 1'b0, 1'b0);
        cycle(9'h003, 1'b0, 1'b0);
        cycle(9'h007, 1'b0, 1'b0);
        cycle(9'h007, 1'b0, 1'b0);
        chk("mid_valid", evt_valid, 1);
        do_reset('0);
        idle(10);

        // Randomized traffic with varying consumer readiness.
        d  = '0;
        rp = 4;
        for (int t = 0; t < 3000; t++) begin
            if (t % 250 == 0) rp = $urandom_range(0, 4);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) d[i] = ~d[i];
            if ($urandom_range(0, 599) == 0) do_reset(d);
            else cycle(d, $urandom_range(0, 3) < rp, $urandom_range(0, 15) == 0);
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
